// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32 sequencer executing ADDI/ADD against a private 32x32 register file.
// Each instruction walks IDLE -> DECODE -> EXEC -> WB -> RESP; illegal encodings skip straight to RESP.
module cpu_sequencer #(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [31:0]         res_data,
  output logic [4:0]          res_rd,
  output logic                res_illegal,
  output logic                busy,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [31:0]           r_instr;
  logic [31:0]           r_result;
  logic [31:0]           r_regs [32];
  logic                  r_res_valid;
  logic [31:0]           r_res_data;
  logic [4:0]            r_res_rd;
  logic                  r_res_illegal;
  logic [RETIRE_W-1:0]   r_retired;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_funct7;
  logic [11:0] w_imm;
  logic        w_is_addi;
  logic        w_is_add;
  logic        w_legal;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_op_b;
  logic [31:0] w_sum;
  logic        w_wr_en;

  // Fields always come from the latched word, so instr may change freely once accepted.
  assign w_opcode  = r_instr[6:0];
  assign w_rd      = r_instr[11:7];
  assign w_funct3  = r_instr[14:12];
  assign w_rs1     = r_instr[19:15];
  assign w_rs2     = r_instr[24:20];
  assign w_funct7  = r_instr[31:25];
  assign w_imm     = r_instr[31:20];

  assign w_is_addi = (w_opcode == 7'b0010011) && (w_funct3 == 3'b000);
  assign w_is_add  = (w_opcode == 7'b0110011) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0000000);
  assign w_legal   = w_is_addi || w_is_add;

  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
  assign w_op_b    = w_is_add ? w_rs2_val : {{20{w_imm[11]}}, w_imm};
  assign w_sum     = w_rs1_val + w_op_b;

  assign w_wr_en   = (r_state == S_WB) && (w_rd != 5'd0);

  assign instr_ready = (r_state == S_IDLE) && rst_n;
  assign busy        = (r_state != S_IDLE);
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_rd      = r_res_rd;
  assign res_illegal = r_res_illegal;
  assign retired     = r_retired;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_rd] <= r_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_instr       <= '0;
      r_result      <= '0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_rd      <= '0;
      r_res_illegal <= 1'b0;
      r_retired     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_res_data    <= '0;
            r_res_rd      <= w_rd;
            r_res_illegal <= 1'b1;
            r_res_valid   <= 1'b1;
            r_state       <= S_RESP;
          end
        end
        S_EXEC: begin
          r_result <= w_sum;
          r_state  <= S_WB;
        end
        S_WB: begin
          r_res_data    <= r_result;
          r_res_rd      <= w_rd;
          r_res_illegal <= 1'b0;
          r_res_valid   <= 1'b1;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (!r_res_illegal && (r_retired != '1)) r_retired <= r_retired + RETIRE_W'(1);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: known instruction sequence with hand-computed results,
// latency, backpressure stability and mid-operation reset.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_illegal;
  logic        busy;
  logic [15:0] retired;

  int n_tests;
  int n_fail;

  cpu_sequencer #(.RETIRE_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .res_illegal (res_illegal),
    .busy        (busy),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction, measure latency (accept cycle counts as cycle 0),
  // optionally hold res_ready low for 'stall' cycles while offering a junk instruction.
  task automatic issue(input string tag, input logic [31:0] ins, input int exp_lat,
                       input logic [31:0] exp_data, input logic [4:0] exp_rd,
                       input logic exp_ill, input int stall, input logic [15:0] exp_ret);
    int lat;
    int guard;
    guard = 0;
    while (!instr_ready && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, ".ready"}, 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = ins;
    tick();
    instr_valid = 1'b0;
    instr       = $urandom;
    lat = 1;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".data"}, res_data, exp_data);
    check({tag, ".rd"}, 32'(res_rd), 32'(exp_rd));
    check({tag, ".ill"}, 32'(res_illegal), 32'(exp_ill));
    for (int k = 0; k < stall; k++) begin
      instr_valid = 1'b1;
      instr       = 32'h00100093;
      tick();
      check({tag, ".stall_valid"}, 32'(res_valid), 32'd1);
      check({tag, ".stall_data"}, res_data, exp_data);
      check({tag, ".stall_rd"}, 32'(res_rd), 32'(exp_rd));
      check({tag, ".stall_ready"}, 32'(instr_ready), 32'd0);
    end
    instr_valid = 1'b0;
    res_ready   = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, ".idle"}, 32'(busy), 32'd0);
    check({tag, ".valid_drop"}, 32'(res_valid), 32'd0);
    check({tag, ".retired"}, 32'(retired), 32'(exp_ret));
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    res_ready   = 1'b0;
    repeat (3) tick();
    check("rst.valid", 32'(res_valid), 32'd0);
    check("rst.data", res_data, 32'd0);
    check("rst.rd", 32'(res_rd), 32'd0);
    check("rst.ill", 32'(res_illegal), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.retired", 32'(retired), 32'd0);
    check("rst.ready_low", 32'(instr_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst.ready_release", 32'(instr_ready), 32'd1);

    issue("addi_x1",  32'h00500093, 4, 32'h00000005, 5'd1, 1'b0, 0, 16'd1);
    issue("addi_x2",  32'hFFF08113, 4, 32'h00000004, 5'd2, 1'b0, 0, 16'd2);
    issue("add_x3",   32'h002081B3, 4, 32'h00000009, 5'd3, 1'b0, 0, 16'd3);
    issue("addi_x0",  32'h00700013, 4, 32'h00000007, 5'd0, 1'b0, 0, 16'd4);
    issue("addi_x4",  32'h00000213, 4, 32'h00000000, 5'd4, 1'b0, 0, 16'd5);
    issue("illegal",  32'h0000007F, 2, 32'h00000000, 5'd0, 1'b1, 0, 16'd5);
    issue("add_x8",   32'h00308433, 4, 32'h0000000E, 5'd8, 1'b0, 3, 16'd6);
    issue("sub_ill",  32'h402081B3, 2, 32'h00000000, 5'd3, 1'b1, 0, 16'd6);
    issue("x3_keep",  32'h00018613, 4, 32'h00000009, 5'd12, 1'b0, 0, 16'd7);
    issue("addi_m1",  32'hFFF00513, 4, 32'hFFFFFFFF, 5'd10, 1'b0, 0, 16'd8);
    issue("wrap",     32'h00250593, 4, 32'h00000001, 5'd11, 1'b0, 0, 16'd9);

    // Abort ADDI x5,x0,9 while it sits in EXEC.
    instr_valid = 1'b1;
    instr       = 32'h00900293;
    tick();
    instr_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("abort.valid", 32'(res_valid), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.retired", 32'(retired), 32'd0);
    check("abort.ready_low", 32'(instr_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("abort.ready_release", 32'(instr_ready), 32'd1);
    repeat (5) begin
      tick();
      check("abort.no_resp", 32'(res_valid), 32'd0);
    end
    issue("x5_zero",  32'h00028313, 4, 32'h00000000, 5'd6, 1'b0, 0, 16'd1);
    issue("x1_clear", 32'h000083B3, 4, 32'h00000000, 5'd7, 1'b0, 0, 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
